// File: rtl/fir_tap_scheduler_if.sv
// fir_tap_scheduler_if: sample FIFO, MAC control and coefficient-port signals of the FIR tap scheduler.
interface fir_tap_scheduler_if #(parameter int AW = 6);
    logic          fifo_empty, fifo_rd, shift_en, mac_en, mac_clr, mac_last, y_valid;
    logic          cw_req, cw_grant, cmem_wen, busy;
    logic [AW-1:0] tap_addr, cw_addr, cmem_addr;
    modport master (
        input  fifo_empty, cw_req, cw_addr,
        output fifo_rd, shift_en, tap_addr, mac_en, mac_clr, mac_last, y_valid,
               cw_grant, cmem_addr, cmem_wen, busy
    );
    modport slave (
        output fifo_empty, cw_req, cw_addr,
        input  fifo_rd, shift_en, tap_addr, mac_en, mac_clr, mac_last, y_valid,
               cw_grant, cmem_addr, cmem_wen, busy
    );
endinterface

// File: rtl/fir_tap_scheduler.sv
// fir_tap_scheduler: per-sample FIR MAC sequencer sharing the coefficient port with host writes.
module fir_tap_scheduler #(
    parameter int N    = 64,
    parameter int AW   = 6,
    parameter int PIPE = 2
) (
    input logic clk,
    input logic rst,
    fir_tap_scheduler_if.master bus
);
    // One counter serves the write burst, the tap walk and the drain, as they never overlap.
    localparam int CW = (AW + 1 > $clog2(PIPE + 1)) ? AW + 1 : $clog2(PIPE + 1);
    typedef enum logic [2:0] {IDLE, COEF, POP, SHIFT, MAC, DRAIN} state_t;
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic          last_coef_q, last_coef_d;
    logic          in_mac;
    assign cnt_inc = cnt_q + CW'(1);
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            last_coef_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            last_coef_q <= last_coef_d;
        end
    end
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        last_coef_d = last_coef_q;
        case (state_q)
            IDLE: begin
                if (!bus.fifo_empty && (!bus.cw_req || last_coef_q)) begin
                    state_d     = POP;
                    last_coef_d = 1'b0;
                end else if (bus.cw_req) begin
                    state_d     = COEF;
                    last_coef_d = 1'b1;
                end
            end
            COEF: begin
                // The burst cap keeps a held request from starving samples.
                if (!bus.cw_req || cnt_inc == CW'(N)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            POP:   state_d = SHIFT;
            SHIFT: state_d = MAC;
            MAC: begin
                state_d = (cnt_q == CW'(N - 1)) ? DRAIN : MAC;
                cnt_d   = (cnt_q == CW'(N - 1)) ? '0 : cnt_inc;
            end
            DRAIN: begin
                state_d = (cnt_q == CW'(PIPE - 1)) ? IDLE : DRAIN;
                cnt_d   = (cnt_q == CW'(PIPE - 1)) ? '0 : cnt_inc;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end
    assign in_mac        = state_q == MAC;
    assign bus.tap_addr  = in_mac ? cnt_q[AW-1:0] : '0;
    assign bus.fifo_rd   = state_q == POP;
    assign bus.shift_en  = state_q == SHIFT;
    assign bus.mac_en    = in_mac;
    assign bus.mac_clr   = in_mac && cnt_q == '0;
    assign bus.mac_last  = in_mac && cnt_q == CW'(N - 1);
    assign bus.y_valid   = state_q == DRAIN && cnt_q == CW'(PIPE - 1);
    assign bus.cw_grant  = state_q == COEF;
    assign bus.cmem_wen  = state_q == COEF && bus.cw_req;
    assign bus.cmem_addr = (state_q == COEF) ? bus.cw_addr : bus.tap_addr;
    assign bus.busy      = state_q != IDLE;
endmodule

// File: tb/tb_fir_tap_scheduler.sv
// tb_fir_tap_scheduler: randomized sample/coefficient traffic checked against a transaction-level scheduler model.
module tb_fir_tap_scheduler;
  localparam int N = 64, AW = 6, PIPE = 2;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  fir_tap_scheduler_if #(.AW(AW)) bus();
  fir_tap_scheduler #(.N(N), .AW(AW), .PIPE(PIPE)) dut (.clk(clk), .rst(rst), .bus(bus));
  typedef struct packed {
    logic fifo_rd, shift_en, mac_en, mac_clr, mac_last, y_valid, cw_grant, cmem_wen, busy;
    logic [AW-1:0] tap_addr, cmem_addr;
  } out_t;
  out_t exp_q[$];
  int   cyc_q[$];
  int   cyc = 0, checks = 0, errors = 0;
  int   rem_h = 0, samp_h = 0;
  bit   last_coef = 1'b1;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    out_t a, e;
    a = {bus.fifo_rd, bus.shift_en, bus.mac_en, bus.mac_clr, bus.mac_last, bus.y_valid,
         bus.cw_grant, bus.cmem_wen, bus.busy, bus.tap_addr, bus.cmem_addr};
    e = '0;
    if (cyc_q.size() > 0 && cyc_q[0] == cyc) begin
      void'(cyc_q.pop_front());
      e = exp_q.pop_front();
    end
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL outputs cyc %0d got %h expected %h", cyc, a, e);
    end
  end
  function automatic void push(input int c, input out_t o);
    cyc_q.push_back(c);
    exp_q.push_back(o);
  endfunction
  task automatic exp_sample(input int t, input int last_tap, output int tn);
    out_t o;
    o = '0; o.busy = 1; o.fifo_rd = 1; push(t + 1, o);
    o = '0; o.busy = 1; o.shift_en = 1; push(t + 2, o);
    for (int k = 0; k <= last_tap; k++) begin
      o = '0; o.busy = 1; o.mac_en = 1;
      o.mac_clr = (k == 0); o.mac_last = (k == N - 1);
      o.tap_addr = AW'(k); o.cmem_addr = AW'(k);
      push(t + 3 + k, o);
    end
    if (last_tap == N - 1)
      for (int d = 0; d < PIPE; d++) begin
        o = '0; o.busy = 1; o.y_valid = (d == PIPE - 1);
        push(t + 3 + N + d, o);
      end
    tn = t + 3 + N + PIPE;
  endtask
  task automatic exp_coef(input int t, inout int rem, inout int addr, output int tn);
    out_t o;
    int w;
    w = (rem < N) ? rem : N;
    for (int i = 0; i < w; i++) begin
      o = '0; o.busy = 1; o.cw_grant = 1; o.cmem_wen = 1; o.cmem_addr = AW'(addr + i);
      push(t + 1 + i, o);
    end
    addr += w;
    rem  -= w;
    if (w == N) tn = t + N + 1;
    else begin
      o = '0; o.busy = 1; o.cw_grant = 1; o.cmem_addr = AW'(addr);
      push(t + w + 1, o);
      tn = t + w + 2;
    end
  endtask
  task automatic step();
    bit acc, popd;
    @(negedge clk);
    acc  = bus.cw_grant && bus.cw_req;
    popd = bus.fifo_rd;
    @(posedge clk);
    #1;
    if (popd) begin
      samp_h--;
      if (samp_h <= 0) bus.fifo_empty = 1'b1;
    end
    if (acc) begin
      bus.cw_addr = bus.cw_addr + 1'b1;
      rem_h--;
      if (rem_h <= 0) bus.cw_req = 1'b0;
    end
  endtask
  task automatic run_op(input int ns, input int nw, input int delay);
    int c0, t, tn, s, rem, addr;
    c0 = cyc; t = cyc; s = ns; rem = nw;
    addr = int'($urandom_range(0, (1 << AW) - 1));
    samp_h = ns; rem_h = nw;
    bus.fifo_empty = (ns == 0);
    bus.cw_addr = AW'(addr);
    bus.cw_req = (nw > 0 && delay == 0);
    if (delay > 0) begin
      exp_sample(t, N - 1, tn);
      t = tn; s--; last_coef = 1'b0;
    end
    while (s > 0 || rem > 0) begin
      if (s > 0 && (rem == 0 || last_coef)) begin
        exp_sample(t, N - 1, tn);
        s--; last_coef = 1'b0;
      end else begin
        exp_coef(t, rem, addr, tn);
        last_coef = 1'b1;
      end
      t = tn;
    end
    while (cyc < t) begin
      if (delay > 0 && cyc == c0 + delay) bus.cw_req = 1'b1;
      step();
    end
  endtask
  initial begin
    int c0, tn, ns, nw, dl;
    bus.fifo_empty = 1'b1;
    bus.cw_req = 1'b0;
    bus.cw_addr = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    run_op(2, 100, 0);
    run_op(1, 0, 0);
    run_op(0, 10, 0);
    run_op(1, 100, 0);
    run_op(1, 5, 20);
    for (int i = 0; i < 25; i++) begin
      ns = int'($urandom_range(0, 2));
      nw = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 100)) : 0;
      if (ns == 0 && nw == 0) ns = 1;
      dl = (ns > 0 && nw > 0 && $urandom_range(0, 2) == 0) ? int'($urandom_range(3, N + 2)) : 0;
      run_op(ns, nw, dl);
      repeat ($urandom_range(0, 2)) step();
    end
    c0 = cyc;
    samp_h = 1;
    bus.fifo_empty = 1'b0;
    exp_sample(c0, 20, tn);
    while (cyc < c0 + 23) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    last_coef = 1'b1;
    samp_h = 0;
    bus.fifo_empty = 1'b1;
    run_op(1, 0, 0);
    run_op(1, 3, 0);
    repeat (4) step();
    checks++;
    if (cyc_q.size() != 0) begin
      errors++;
      $display("FAIL %0d scheduled records never compared", cyc_q.size());
    end
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL busy %b at end, expected 0", bus.busy);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    if (errors != 0) begin
      $display("FAIL %0d errors", errors);
      $fatal(1);
    end
    $display("PASS");
    $finish;
  end
  initial begin
    #5000000;
    $display("FAIL timeout cyc %0d expected completion", cyc);
    $fatal(1);
  end
endmodule

// File: doc/fir_tap_scheduler.md
# fir_tap_scheduler

Single-clock sequencer for the FIR multiply-accumulate datapath. For each input sample it pops the sample FIFO, shifts the delay line, walks the tap address over all N coefficients, and flags the accumulator result. It also arbitrates the single coefficient-memory port between these tap reads and host coefficient writes, so coefficients can be reloaded between samples without corrupting a computation in progress.

## Interface
- N, 64, number of taps (2 ≤ N ≤ 2^AW)
- AW, 6, tap/coefficient address width
- PIPE, 2, MAC pipeline depth in cycles from last mac_en to result at accumulator output (PIPE ≥ 1)

- clk  in  1  operating clock; single clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- fifo_empty  in  1  sample FIFO empty flag
- fifo_rd  out  1  one-cycle FIFO pop
- shift_en  out  1  one-cycle delay-line shift strobe
- tap_addr  out  AW  current tap index, shared by IMEM and CMEM reads
- mac_en  out  1  MAC accumulate enable
- mac_clr  out  1  first tap: load the product instead of accumulating
- mac_last  out  1  last tap (N-1)
- y_valid  out  1  one-cycle pulse: accumulator output is final
- cw_req  in  1  host coefficient-write request, held high for the whole burst
- cw_addr  in  AW  host coefficient address
- cw_grant  out  1  a write is accepted this cycle when cw_grant & cw_req
- cmem_addr  out  AW  CMEM address (mux of tap_addr / cw_addr)
- cmem_wen  out  1  CMEM write enable, active-high
- busy  out  1  FSM not in IDLE

## Operation
- States: IDLE, COEF, POP, SHIFT, MAC, DRAIN.
- Arbitration happens only in IDLE. Requests are a sample (!fifo_empty) and a coefficient write (cw_req).
  - With one request, serve it.
  - With both, serve the one not served last. The last-served flag resets to "coef", so a sample wins the first tie.
- COEF:
  - cw_grant=1.
  - cmem_wen = cw_req.
  - cmem_addr = cw_addr.
  - A write counter (AW+1 bits) counts accepted writes.
  - Exit to IDLE when cw_req is low, or after the Nth accepted write (burst cap). The cap prevents a held cw_req from starving samples.
- POP: fifo_rd=1 for one cycle, then SHIFT.
- SHIFT: shift_en=1 for one cycle, then MAC. The FIFO data is valid during this cycle.
- MAC:
  - Runs exactly N cycles with mac_en=1, tap_addr=0..N-1, and cmem_addr=tap_addr.
  - mac_clr=1 only at tap 0; mac_last=1 only at tap N-1.
  - cw_req is ignored (cw_grant=0, cmem_wen=0).
  - After tap N-1, go to DRAIN.
- DRAIN:
  - PIPE cycles, counted 0..PIPE-1.
  - y_valid=1 on count PIPE-1, then IDLE.
- Outside COEF and MAC: cmem_addr=0, cmem_wen=0.
- tap_addr returns to 0 on leaving MAC and holds 0 elsewhere. No wrap occurs when N=2^AW because the counter stops at N-1.
- busy=1 in every state except IDLE.
- fifo_empty is sampled only in IDLE. A pop is never issued when fifo_empty=1.

## Timing
- All outputs are registered or decoded from registered state. There are no combinational paths from inputs to outputs except cmem_wen and cmem_addr in COEF.
- Reset: state=IDLE, last-served=coef, all counters 0, every output 0.
- Reset mid-operation takes effect at the next edge. mac_en, y_valid and cmem_wen drop immediately. A partial result is never flagged.
- Sample timeline, with cycle 0 = POP:
  - shift_en at cycle 1.
  - mac_en at cycles 2..N+1 (mac_clr at 2, mac_last at N+1).
  - y_valid at N+1+PIPE.
  - IDLE at N+2+PIPE.
  - Sample period is N+PIPE+3 cycles including the IDLE cycle.
- Coefficient burst: grant begins the cycle after IDLE sees cw_req. Each cycle with cw_req&cw_grant writes one word. The host advances cw_addr on each accepted write.

## Test plan
- Single sample (N=64, PIPE=2): fifo_empty falls at cycle 0. Required: fifo_rd at cycle 1, shift_en at 2, mac_en for 64 cycles 3..66 with tap_addr 0..63, mac_clr at 3, mac_last at 66, y_valid at 68, busy low at 69.
- Coefficient burst: cw_req held 10 cycles from IDLE with cw_addr 0..9. Required: 10 cmem_wen pulses at matching addresses, cmem_wen low while cw_req low, return to IDLE.
- Burst cap: cw_req held 100 cycles with the FIFO non-empty. Required: exactly 64 writes, then one sample processed (POP) before the next grant.
- Contention tie after reset: cw_req and !fifo_empty assert together. Required: sample served first, then the coefficient burst, then the next sample (alternation).
- cw_req asserted during MAC. Required: no cmem_wen and cmem_addr equals tap_addr for all 64 taps; grant only after y_valid and IDLE.
- rst pulsed at tap 20. Required: next cycle all outputs 0 and IDLE, no y_valid. A new sample afterwards meets the single-sample timeline exactly.
